ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 device-to-host frame receiver for the keyboard path. It conditions the raw `ps2_clk_in`/`ps2_dat_in` pins and deserializes 11-bit PS/2 frames. Each frame is checked for start, odd parity and stop bits, and guarded by an inter-edge timeout. Each good scan code goes to the downstream scan-code-to-ASCII decoder as a one-cycle `scan_valid` pulse; bad frames are reported as a `frame_err` pulse.

## Interface
Parameters:
- `FILTER_LEN`, 16: consecutive identical synchronized samples required before a filtered line changes level (≥2).
- `TIMEOUT`, 200000: clock cycles without a filtered clk falling edge before an in-progress frame is abandoned (2 ms at 100 MHz).

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `kbd_clr`  in  1  reset: asynchronous, active-high.
- `ps2_clk_in`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_dat_in`  in  1  raw PS/2 data pin, asynchronous.
- `scan_code`  out  8  last correctly received byte; held until the next good frame.
- `scan_valid`  out  1  one-cycle pulse; `scan_code` is new this cycle.
- `frame_err`  out  1  one-cycle pulse; frame rejected.
- `err_kind`  out  2  cause of the last rejection (0 none, 1 parity, 2 stop, 3 timeout); held.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- Synchronizer: 2 flops per pin.
- Filter (per line):
  - The synchronized sample shifts into a FILTER_LEN-bit history.
  - The filtered level is registered 1 when the history is all ones and 0 when it is all zeros; otherwise it holds.
- Edge detect: `fall` = previous filtered clk AND NOT current filtered clk. Filtered data is sampled in the `fall` cycle.
- FSM, advancing only on `fall` except for timeout:
  - IDLE: data=0 → DATA, bit count 0. Data=1 → stay in IDLE, no error (spurious edge).
  - DATA: shift LSB-first (`sh <= {dat, sh[7:1]}`). After the 8th bit → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: accept if XOR(sh, parity)=1 and data=1. On accept: `scan_code` ← `sh`, `scan_valid`=1, `err_kind` unchanged. Otherwise: `frame_err`=1 and set `err_kind` (parity checked first; parity wins if both fail). Either way → IDLE.
- Timeout counter:
  - Cleared in IDLE and on every `fall`; increments otherwise.
  - Reaching TIMEOUT−1 outside IDLE → `frame_err`=1, `err_kind`=3, → IDLE.
  - Width is clog2(TIMEOUT); no wrap is possible.
- On `kbd_clr` (asynchronous, any state, mid-frame included):
  - FSM → IDLE.
  - Histories and synchronizers → all ones; filtered levels → 1 (idle bus).
  - `scan_code`=0, `scan_valid`=0, `frame_err`=0, `err_kind`=0, `busy`=0, counters=0.
  - A partial frame is discarded silently.
- `scan_valid` and `frame_err` are never high in the same cycle. The block has no flow control: downstream must consume within one cycle.

## Timing
- A raw pin transition reaches the filtered level FILTER_LEN+3 rising edges after the first edge that samples the new value: 2 sync, FILTER_LEN history, 1 filter register.
- `scan_valid`/`frame_err` are registered high in the cycle after the STOP-state `fall`. That is FILTER_LEN+4 edges (20 at default) after the first edge sampling `ps2_clk_in` low for the stop bit. Both clear the following cycle.
- Timeout `frame_err` is high in the cycle after the counter reaches TIMEOUT−1.
- A `fall` in the same cycle the counter reaches TIMEOUT−1: the `fall` wins, the counter clears and there is no timeout.
- `busy` rises the cycle after the start-bit `fall` and drops together with the result pulse.
- Back-to-back frames need no gap beyond normal PS/2 idle. The FSM is ready in IDLE the cycle after STOP.

## Test plan
- Good frame: send 0x1C (start 0, bits LSB-first, parity 0, stop 1, 40 µs half-period). Required: one `scan_valid` with `scan_code`=0x1C, `frame_err`=0, `busy` low afterwards.
- Parity error: 0x1C with parity=1. Required: `frame_err` pulse, `err_kind`=1, `scan_code` keeps its previous value, no `scan_valid`.
- Stop error: 0xF0 with stop=0. Required: `frame_err`, `err_kind`=2. Then a good 0x12 frame gives `scan_valid` with 0x12.
- Timeout: 4 data bits, then clk held high for TIMEOUT+100 cycles. Required: `frame_err` with `err_kind`=3 exactly once and `busy`=0. A following good 0x5A is received correctly.
- Glitch rejection: superimpose low pulses of FILTER_LEN−1 cycles on idle clk and on data mid-bit. Required: no state change, and a good frame 0x29 still decodes as 0x29.
- Reset mid-frame: assert `kbd_clr` for 3 cycles after the 5th data bit. Required: all outputs 0 immediately. The next full frame 0x45 yields `scan_valid` with `scan_code`=0x45 and no error.

Source files
------------

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with pin filtering, frame checking and inter-edge timeout.
module ps2_rx #(
    parameter int FILTER_LEN = 16,
    parameter int TIMEOUT    = 200000
) (
    input  logic       clock,
    input  logic       kbd_clr,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic [1:0] err_kind,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]            sync_c, sync_d;
    logic [FILTER_LEN-1:0] hist_c, hist_d;
    logic                  clk_f, dat_f, clk_p, fall, timeout;
    state_t                state, state_n;
    logic [2:0]            cnt, cnt_n;
    logic [7:0]            sh, sh_n, code_n;
    logic                  par, par_n, valid_n, err_n;
    logic [1:0]            kind_n;
    logic [TW-1:0]         tcnt, tcnt_n;

    // Lines reset to the idle-bus level so release of kbd_clr never produces an edge.
    always_ff @(posedge clock or posedge kbd_clr) begin
        if (kbd_clr) begin
            sync_c <= '1;
            sync_d <= '1;
            hist_c <= '1;
            hist_d <= '1;
            clk_f  <= 1'b1;
            dat_f  <= 1'b1;
            clk_p  <= 1'b1;
        end else begin
            sync_c <= {sync_c[0], ps2_clk_in};
            sync_d <= {sync_d[0], ps2_dat_in};
            hist_c <= {hist_c[FILTER_LEN-2:0], sync_c[1]};
            hist_d <= {hist_d[FILTER_LEN-2:0], sync_d[1]};
            clk_f  <= &hist_c ? 1'b1 : ~|hist_c ? 1'b0 : clk_f;
            dat_f  <= &hist_d ? 1'b1 : ~|hist_d ? 1'b0 : dat_f;
            clk_p  <= clk_f;
        end
    end

    assign fall = clk_p & ~clk_f;
    assign busy = state != IDLE;

    always_ff @(posedge clock or posedge kbd_clr) begin
        if (kbd_clr) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_kind   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            par        <= par_n;
            tcnt       <= tcnt_n;
            scan_code  <= code_n;
            scan_valid <= valid_n;
            frame_err  <= err_n;
            err_kind   <= kind_n;
        end
    end

    // A fall coinciding with the last timeout count wins over the timeout.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        par_n   = par;
        code_n  = scan_code;
        valid_n = 1'b0;
        err_n   = 1'b0;
        kind_n  = err_kind;
        timeout = state != IDLE && !fall && tcnt == TMAX;
        tcnt_n  = (state == IDLE || fall || timeout) ? '0 : tcnt + 1'b1;
        if (timeout) begin
            state_n = IDLE;
            err_n   = 1'b1;
            kind_n  = 2'd3;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    state_n = dat_f ? IDLE : DATA;
                    cnt_n   = '0;
                end
                DATA: begin
                    sh_n    = {dat_f, sh[7:1]};
                    cnt_n   = cnt + 1'b1;
                    state_n = cnt == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = dat_f;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    if (^{sh, par} && dat_f) begin
                        code_n  = sh;
                        valid_n = 1'b1;
                    end else begin
                        err_n  = 1'b1;
                        kind_n = ^{sh, par} ? 2'd2 : 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed frames against ps2_rx with hand-computed expectations.
module tb_ps2_rx;
    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       kbd_clr = 1'b1;
    logic       clk_pin = 1'b1;
    logic       dat_pin = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err, busy;
    logic [1:0] err_kind;

    int n_chk = 0, n_err = 0;
    int cyc = 0, stop_cyc = 0, vcyc = 0;
    int nv = 0, ne = 0, both = 0;
    int v0, e0;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clock(clock), .kbd_clr(kbd_clr), .ps2_clk_in(clk_pin), .ps2_dat_in(dat_pin),
        .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err),
        .err_kind(err_kind), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (scan_valid) begin
            nv++;
            vcyc = cyc;
        end
        if (frame_err) ne++;
        if (scan_valid && frame_err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [10:0] frm(input logic [7:0] d, input bit pflip, input bit stop);
        return {stop, ~^d ^ pflip, d, 1'b0};
    endfunction

    task automatic send(input logic [10:0] f, input int n, input bit g);
        for (int i = 0; i < n; i++) begin
            dat_pin = f[i];
            if (g) begin
                wt(HALF - 6);
                dat_pin = ~f[i];
                wt(FL - 1);
                dat_pin = f[i];
                wt(3);
            end else wt(HALF);
            clk_pin  = 1'b0;
            stop_cyc = cyc;
            wt(HALF);
            clk_pin = 1'b1;
        end
        dat_pin = 1'b1;
        wt(2 * HALF);
    endtask

    task automatic mark;
        v0 = nv;
        e0 = ne;
    endtask

    initial begin
        #2;
        chk("rst_code", scan_code, 8'h00);
        chk("rst_valid", scan_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_kind", err_kind, 0);
        chk("rst_busy", busy, 0);
        wt(3);
        kbd_clr = 1'b0;
        wt(20);

        mark();
        send(frm(8'h1C, 0, 1), 11, 0);
        chk("good_nv", nv - v0, 1);
        chk("good_code", scan_code, 8'h1C);
        chk("good_ne", ne - e0, 0);
        chk("good_busy", busy, 0);
        chk("good_lat", vcyc - stop_cyc, FL + 4);

        mark();
        send(frm(8'h1C, 1, 1), 11, 0);
        chk("par_ne", ne - e0, 1);
        chk("par_kind", err_kind, 1);
        chk("par_code", scan_code, 8'h1C);
        chk("par_nv", nv - v0, 0);

        mark();
        send(frm(8'hF0, 0, 0), 11, 0);
        chk("stop_ne", ne - e0, 1);
        chk("stop_kind", err_kind, 2);
        chk("stop_nv", nv - v0, 0);
        mark();
        send(frm(8'h12, 0, 1), 11, 0);
        chk("f12_nv", nv - v0, 1);
        chk("f12_code", scan_code, 8'h12);
        chk("f12_kind", err_kind, 2);

        mark();
        send(frm(8'hA5, 0, 1), 5, 0);
        chk("to_busy_mid", busy, 1);
        wt(TO + 100);
        chk("to_ne", ne - e0, 1);
        chk("to_kind", err_kind, 3);
        chk("to_busy", busy, 0);
        chk("to_nv", nv - v0, 0);
        mark();
        send(frm(8'h5A, 0, 1), 11, 0);
        chk("f5a_nv", nv - v0, 1);
        chk("f5a_code", scan_code, 8'h5A);
        chk("f5a_ne", ne - e0, 0);

        mark();
        clk_pin = 1'b0;
        wt(FL - 1);
        clk_pin = 1'b1;
        wt(HALF);
        chk("gl_busy", busy, 0);
        chk("gl_evt", (nv - v0) + (ne - e0), 0);
        send(frm(8'h29, 0, 1), 11, 1);
        chk("gl_nv", nv - v0, 1);
        chk("gl_code", scan_code, 8'h29);
        chk("gl_ne", ne - e0, 0);

        mark();
        send(frm(8'h33, 0, 1), 6, 0);
        chk("rm_busy_mid", busy, 1);
        kbd_clr = 1'b1;
        #1;
        chk("rm_code", scan_code, 8'h00);
        chk("rm_kind", err_kind, 0);
        chk("rm_busy", busy, 0);
        chk("rm_flags", {scan_valid, frame_err}, 0);
        wt(3);
        kbd_clr = 1'b0;
        wt(20);
        send(frm(8'h45, 0, 1), 11, 0);
        chk("f45_nv", nv - v0, 1);
        chk("f45_code", scan_code, 8'h45);
        chk("f45_ne", ne - e0, 0);
        chk("f45_kind", err_kind, 0);

        chk("excl", both, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
